// File: rtl/dm_dump_reader.sv
// Streams a contiguous (wrapping) range of data-RAM words out over a valid/ready port.
// One RAM read per word; each word goes FETCH -> CAPTURE -> SEND.
module dm_dump_reader #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    FIN     = 3'd4
  } state_t;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   REM_ONE = (AW+1)'(1);
  localparam logic [AW:0]   REM_ZERO = '0;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW:0]   remaining;

  // ptr is a free-running modulo-2^AW counter, so a full 1024-word dump wraps naturally.
  assign ram_addr = ptr;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      ram_re    <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != REM_ZERO) begin
              ptr       <= base_addr;
              remaining <= count;
              ram_re    <= 1'b1;
              state     <= FETCH;
            end else begin
              state <= FIN;
            end
          end
        end
        FETCH: begin
          ram_re <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          out_data  <= ram_rdata;
          out_addr  <= ptr;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - REM_ONE;
            ptr       <= ptr + PTR_ONE;
            if (remaining != REM_ONE) begin
              ram_re <= 1'b1;
              state  <= FETCH;
            end else begin
              state <= FIN;
            end
          end
        end
        FIN: begin
          // done is registered on leaving FIN, so the pulse lands two cycles after a count=0 start.
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ram_re    <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_dump_reader.sv
// Directed bench for dm_dump_reader: behavioural RAM, beat monitor, one task per scenario.
module tb_dm_dump_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] count = '0;
  logic        ram_re;
  logic [9:0]  ram_addr;
  logic [31:0] ram_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [9:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int passes = 0;
  int re_cnt = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  logic [9:0]  q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] mem[1024];

  dm_dump_reader #(.AW(10), .DW(32)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .ram_re(ram_re), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(input logic [9:0] a);
    if (a == 10'd5) return 32'hAAAA_AAAA;
    if (a == 10'd6) return 32'hBBBB_BBBB;
    if (a == 10'd7) return 32'hCCCC_CCCC;
    return {16'hDA7A, 6'd0, a};
  endfunction

  always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_addr];

  always @(negedge clk) begin
    if (reset) begin
      if (ram_re) re_cnt++;
      if (done) done_cnt++;
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        q_addr.push_back(out_addr);
        q_data.push_back(out_data);
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [9:0] b, input logic [10:0] c);
    start = 1'b1; base_addr = b; count = c;
    cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      @(negedge clk);
      if (done_cnt > d0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    checks++; if (ram_re !== 1'b0) $display("FAIL rst_ram_re got %b want 0", ram_re); else passes++;
    checks++; if (ram_addr !== 10'd0) $display("FAIL rst_ram_addr got %h want 000", ram_addr); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else passes++;
    checks++; if (out_addr !== 10'd0) $display("FAIL rst_out_addr got %h want 000", out_addr); else passes++;
    checks++; if (out_data !== 32'd0) $display("FAIL rst_out_data got %h want 0", out_data); else passes++;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_busy_done got %b%b want 00", busy, done); else passes++;
    start = 1'b1; count = 11'd3;
    cyc;
    checks++; if (busy !== 1'b0) $display("FAIL rst_start_held got busy=%b want 0", busy); else passes++;
    start = 1'b0;
    #3 reset = 1'b1;
    cyc;
  endtask

  task automatic test_basic;
    int b0, d0, r0;
    bit ok;
    logic [9:0]  ea[3];
    logic [31:0] ed[3];
    ea = '{10'd5, 10'd6, 10'd7};
    ed = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
    b0 = q_addr.size(); d0 = done_cnt; r0 = re_cnt;
    out_ready = 1'b1;
    pulse_start(10'd5, 11'd3);
    checks++; if (busy !== 1'b1 || ram_re !== 1'b1) $display("FAIL basic_fetch got busy=%b re=%b want 1 1", busy, ram_re); else passes++;
    cyc;
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_lat2 got out_valid=%b want 0", out_valid); else passes++;
    cyc;
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_lat3 got out_valid=%b want 1", out_valid); else passes++;
    wait_done(d0, 50, ok);
    checks++; if (!ok) $display("FAIL basic_done_timeout got none want done"); else passes++;
    repeat (3) cyc;
    checks++; if (q_addr.size() - b0 != 3) $display("FAIL basic_beats got %0d want 3", q_addr.size() - b0); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b0 + i >= q_addr.size()) $display("FAIL basic_beat%0d got missing want %h/%h", i, ea[i], ed[i]);
      else if (q_addr[b0+i] !== ea[i] || q_data[b0+i] !== ed[i])
        $display("FAIL basic_beat%0d got %h/%h want %h/%h", i, q_addr[b0+i], q_data[b0+i], ea[i], ed[i]);
      else passes++;
    end
    checks++; if (done_cnt - d0 != 1) $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (re_cnt - r0 != 3) $display("FAIL basic_reads got %0d want 3", re_cnt - r0); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy); else passes++;
  endtask

  task automatic test_wrap;
    int b0, d0;
    bit ok;
    logic [9:0] ea[3];
    ea = '{10'h3FE, 10'h3FF, 10'h000};
    b0 = q_addr.size(); d0 = done_cnt;
    pulse_start(10'h3FE, 11'd3);
    wait_done(d0, 50, ok);
    checks++; if (!ok) $display("FAIL wrap_done_timeout got none want done"); else passes++;
    cyc;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b0 + i >= q_addr.size()) $display("FAIL wrap_beat%0d got missing want %h", i, ea[i]);
      else if (q_addr[b0+i] !== ea[i] || q_data[b0+i] !== exp_data(ea[i]))
        $display("FAIL wrap_beat%0d got %h/%h want %h/%h", i, q_addr[b0+i], q_data[b0+i], ea[i], exp_data(ea[i]));
      else passes++;
    end
  endtask

  task automatic test_backpressure;
    int b0, d0, bad;
    bit ok;
    logic [9:0]  a;
    logic [31:0] d;
    b0 = q_addr.size(); d0 = done_cnt; bad = 0;
    out_ready = 1'b0;
    pulse_start(10'h010, 11'd2);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    checks++; if (!ok) $display("FAIL bp_valid_timeout got none want out_valid"); else passes++;
    a = out_addr; d = out_data;
    checks++; if (a !== 10'h010 || d !== exp_data(10'h010)) $display("FAIL bp_first got %h/%h want 010/%h", a, d, exp_data(10'h010)); else passes++;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_addr !== a || out_data !== d) bad++;
    end
    checks++; if (bad != 0) $display("FAIL bp_stable got %0d unstable cycles want 0", bad); else passes++;
    checks++; if (q_addr.size() != b0) $display("FAIL bp_no_beat got %0d beats want 0", q_addr.size() - b0); else passes++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (q_addr.size() - b0 != 1) $display("FAIL bp_one_beat got %0d want 1", q_addr.size() - b0); else passes++;
    wait_done(d0, 50, ok);
    checks++; if (!ok) $display("FAIL bp_done_timeout got none want done"); else passes++;
    cyc;
    checks++;
    if (q_addr.size() - b0 != 2) $display("FAIL bp_beats got %0d want 2", q_addr.size() - b0);
    else if (q_addr[b0+1] !== 10'h011 || q_data[b0+1] !== exp_data(10'h011))
      $display("FAIL bp_second got %h/%h want 011/%h", q_addr[b0+1], q_data[b0+1], exp_data(10'h011));
    else passes++;
  endtask

  task automatic test_count_zero;
    int r0, v0, d0;
    r0 = re_cnt; v0 = valid_cnt; d0 = done_cnt;
    pulse_start(10'h123, 11'd0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL zero_fin got busy=%b done=%b want 1 0", busy, done); else passes++;
    cyc;
    checks++; if (done !== 1'b1) $display("FAIL zero_done_at2 got %b want 1", done); else passes++;
    cyc;
    checks++; if (done !== 1'b0) $display("FAIL zero_done_width got %b want 0", done); else passes++;
    repeat (3) cyc;
    checks++; if (re_cnt != r0) $display("FAIL zero_reads got %0d want 0", re_cnt - r0); else passes++;
    checks++; if (valid_cnt != v0) $display("FAIL zero_valid got %0d want 0", valid_cnt - v0); else passes++;
    checks++; if (done_cnt - d0 != 1) $display("FAIL zero_done_count got %0d want 1", done_cnt - d0); else passes++;
  endtask

  task automatic test_start_ignored;
    int b0, d0, r0, k;
    b0 = q_addr.size(); d0 = done_cnt; r0 = re_cnt;
    pulse_start(10'h020, 11'd4);
    base_addr = 10'h100; count = 11'd7;
    k = 0;
    while (busy && k < 100) begin
      start = 1'b1;
      cyc;
      k++;
    end
    start = 1'b0;
    checks++; if (k >= 100) $display("FAIL ign_timeout got busy after %0d cycles want idle", k); else passes++;
    repeat (5) cyc;
    checks++; if (q_addr.size() - b0 != 4) $display("FAIL ign_beats got %0d want 4", q_addr.size() - b0); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b0 + i >= q_addr.size()) $display("FAIL ign_beat%0d got missing want %h", i, 10'(10'h020 + i));
      else if (q_addr[b0+i] !== 10'(10'h020 + i) || q_data[b0+i] !== exp_data(10'(10'h020 + i)))
        $display("FAIL ign_beat%0d got %h/%h want %h", i, q_addr[b0+i], q_data[b0+i], 10'(10'h020 + i));
      else passes++;
    end
    checks++; if (done_cnt - d0 != 1 || re_cnt - r0 != 4) $display("FAIL ign_counts got done=%0d reads=%0d want 1 4", done_cnt - d0, re_cnt - r0); else passes++;
  endtask

  task automatic test_full;
    int b0, d0, r0, bad;
    bit ok;
    logic [9:0] ea;
    b0 = q_addr.size(); d0 = done_cnt; r0 = re_cnt; bad = 0;
    pulse_start(10'h155, 11'd1024);
    wait_done(d0, 4000, ok);
    checks++; if (!ok) $display("FAIL full_done_timeout got none want done"); else passes++;
    cyc;
    checks++; if (q_addr.size() - b0 != 1024) $display("FAIL full_beats got %0d want 1024", q_addr.size() - b0); else passes++;
    for (int i = 0; i < 1024 && b0 + i < q_addr.size(); i++) begin
      ea = 10'(10'h155 + i);
      if (q_addr[b0+i] !== ea || q_data[b0+i] !== exp_data(ea)) bad++;
    end
    checks++; if (bad != 0) $display("FAIL full_content got %0d bad beats want 0", bad); else passes++;
    checks++; if (re_cnt - r0 != 1024) $display("FAIL full_reads got %0d want 1024", re_cnt - r0); else passes++;
  endtask

  task automatic test_reset_abort;
    int b0, d0, r0, k;
    bit ok;
    b0 = q_addr.size(); d0 = done_cnt;
    pulse_start(10'h040, 11'd4);
    k = 0;
    while (q_addr.size() == b0 && k < 20) begin cyc; k++; end
    repeat (2) cyc;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ram_re !== 1'b0 || ram_addr !== 10'd0 || out_valid !== 1'b0 || out_addr !== 10'd0 ||
        out_data !== 32'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_outputs got re=%b ra=%h v=%b oa=%h od=%h busy=%b done=%b want all 0",
               ram_re, ram_addr, out_valid, out_addr, out_data, busy, done);
    else passes++;
    r0 = re_cnt;
    repeat (2) cyc;
    #3 reset = 1'b1;
    repeat (4) cyc;
    checks++; if (re_cnt != r0 || done_cnt != d0) $display("FAIL abort_quiet got reads=%0d done=%0d want 0 0", re_cnt - r0, done_cnt - d0); else passes++;
    b0 = q_addr.size();
    pulse_start(10'h050, 11'd2);
    wait_done(d0, 50, ok);
    checks++; if (!ok) $display("FAIL abort_redo_timeout got none want done"); else passes++;
    cyc;
    checks++;
    if (q_addr.size() - b0 != 2) $display("FAIL abort_redo_beats got %0d want 2", q_addr.size() - b0);
    else if (q_addr[b0] !== 10'h050 || q_data[b0] !== exp_data(10'h050) || q_addr[b0+1] !== 10'h051 || q_data[b0+1] !== exp_data(10'h051))
      $display("FAIL abort_redo_data got %h/%h %h/%h want 050 051", q_addr[b0], q_data[b0], q_addr[b0+1], q_data[b0+1]);
    else passes++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = exp_data(10'(i));
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_count_zero;
    test_start_ignored;
    test_full;
    test_reset_abort;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dm_dump_reader.md
DM_DUMP_READER -- requirements
Module: dm_dump_reader

Interface
REQ-001 Parameter AW, default 10: data-RAM word-address width (1024 words, 0x000-0x3FF).
REQ-002 Parameter DW, default 32: data word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, independent of clk.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 base_addr  input  AW  first word address; sampled with start.
REQ-007 count  input  AW+1  number of words to dump, 0..1024; sampled with start.
REQ-008 ram_re  output  1  read enable to data RAM.
REQ-009 ram_addr  output  AW  word address to data RAM.
REQ-010 ram_rdata  input  DW  RAM read data, valid exactly one cycle after the ram_re cycle.
REQ-011 out_valid  output  1  dump word available.
REQ-012 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both 1.
REQ-013 out_addr  output  AW  address of the presented word.
REQ-014 out_data  output  DW  presented word.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when the dump completes.

Function
REQ-017 FSM states shall be IDLE, FETCH, CAPTURE, SEND and FIN.
REQ-018 IDLE: on start=1 with count!=0, latch base_addr into ptr and count into remaining, then go to FETCH.
REQ-019 IDLE: on start=1 with count=0, go directly to FIN without issuing any RAM read.
REQ-020 FETCH: drive ram_re=1 and ram_addr=ptr for exactly one cycle, then go to CAPTURE.
REQ-021 CAPTURE: register ram_rdata into out_data and ptr into out_addr, then go to SEND.
REQ-022 SEND: hold out_valid=1 with out_data/out_addr stable until the handshake completes.
REQ-023 On the SEND handshake, decrement remaining and increment ptr modulo 2^AW (0x3FF wraps to 0x000).
REQ-024 After the SEND handshake, go to FETCH if the decremented remaining is non-zero, else go to FIN.
REQ-025 FIN: assert done=1 for one cycle, then return to IDLE.
REQ-026 start shall be ignored in every state other than IDLE, including FIN.
REQ-027 ram_re shall be 0 outside FETCH, and ram_addr shall hold ptr at all times.
REQ-028 out_valid shall be 1 only in SEND.
REQ-029 Minimum throughput shall be one word per 3 cycles with out_ready held high.
REQ-030 Latency from start to first out_valid shall be 3 cycles.
REQ-031 count=1024 shall dump every RAM word exactly once, wrapping from base_addr.

Reset
REQ-032 While reset=0: state=IDLE, ram_re=0, ram_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0, ptr=0, remaining=0.
REQ-033 Reset asserted mid-dump shall abort the dump immediately, with no done pulse and no further RAM reads.
REQ-034 After reset release, the first rising edge shall be treated as normal IDLE operation.

Verification
REQ-035 RAM[5..7]=A,B,C, base=5, count=3, out_ready=1 -> words (5,A),(6,B),(7,C) in order, done pulses exactly once, busy=0 afterwards.
REQ-036 base=0x3FE, count=3 -> out_addr sequence is 0x3FE, 0x3FF, 0x000.
REQ-037 out_ready=0 for 5 cycles during SEND -> out_valid, out_data and out_addr stay stable; exactly one beat is delivered once ready rises.
REQ-038 count=0 -> no ram_re cycles, done pulses 2 cycles after start, out_valid never asserts.
REQ-039 reset driven low asynchronously (between clock edges) during the second beat -> all outputs are 0 immediately; a new start after release dumps correctly.
REQ-040 start pulsed while busy -> ignored; remaining dump is unaffected.
